// File: rtl/npu_pkg.sv
// Shared definitions for the npu job sequencer.
// - npu bus select codes and control-register indices.
// - Word-count helpers for the in_vec / fc1 / fc2 source segments.
// - Sequencer state enum and the npu bus request struct.
package npu_pkg;

  localparam logic [2:0] SEL_IN   = 3'b000;
  localparam logic [2:0] SEL_FC1  = 3'b011;
  localparam logic [2:0] SEL_FC2  = 3'b100;
  localparam logic [2:0] SEL_CTRL = 3'b101;

  localparam logic [11:0] CTRL_IDX_START  = 12'd1;
  localparam logic [11:0] CTRL_IDX_DONE   = 12'd0;
  localparam logic [11:0] CTRL_IDX_RESULT = 12'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IN, S_LOAD_FC1, S_LOAD_FC2, S_DRAIN,
    S_START, S_POLL, S_RES_RD, S_RES_WAIT, S_OUT
  } seq_state_e;

  typedef struct packed {
    logic        ena;
    logic        wea;
    logic [15:0] addra;
    logic [31:0] dina;
  } npu_req_t;

  // int8 elements packed four per word
  function automatic int unsigned in_words(input int unsigned n);
    return (n + 3) / 4;
  endfunction

  function automatic int unsigned fc1_words(input int unsigned m, input int unsigned n);
    return (m * n + 3) / 4;
  endfunction

  function automatic int unsigned fc2_words(input int unsigned m);
    return (m + 3) / 4;
  endfunction

  function automatic logic [15:0] npu_addr(input logic [2:0] sel, input logic [11:0] idx);
    return {1'b0, sel, idx};
  endfunction

endpackage

// File: rtl/npu_word_streamer.sv
// SRAM-to-npu word streamer, one word per cycle.
// While run is high a read of base+k is issued each cycle; the returned word
// is written to npu {sel, idx=k} the following cycle. k wraps to 0 on the last
// word (done pulse) so the owner can switch segment with no bubble.
// Ports: clk/rst_ni; run, base, count, sel (segment control); done (last read);
// mem_en/mem_addr/mem_rdata (source SRAM); wr (npu write request).
module npu_word_streamer
  import npu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        run,
  input  logic [15:0] base,
  input  logic [11:0] count,
  input  logic [2:0]  sel,
  output logic        done,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output npu_req_t    wr
);

  logic [11:0] k;
  logic        last;
  logic        wr_vld;
  logic [2:0]  wr_sel;
  logic [11:0] wr_idx;

  assign last     = (k == count - 12'd1);
  assign done     = run & last;
  assign mem_en   = run;
  assign mem_addr = run ? base + {4'b0, k} : '0;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      k      <= '0;
      wr_vld <= 1'b0;
      wr_sel <= '0;
      wr_idx <= '0;
    end else begin
      wr_vld <= run;
      wr_sel <= sel;
      wr_idx <= k;
      if (run) k <= last ? '0 : k + 12'd1;
    end
  end

  // SRAM data lands one cycle after the read, aligned with the write slot
  always_comb begin
    wr = '0;
    if (wr_vld) begin
      wr.ena   = 1'b1;
      wr.wea   = 1'b1;
      wr.addra = npu_addr(wr_sel, wr_idx);
      wr.dina  = mem_rdata;
    end
  end

endmodule

// File: rtl/npu_job_sequencer.sv
// npu job sequencer: sole master of the npu bus port.
// Takes a job descriptor, streams in_vec/fc1/fc2 from source SRAM into npu,
// writes start, polls done with back-to-back pipelined reads, reads the
// 24-bit result and presents it sign-extended on a valid/ready port.
// Ports: job_* (descriptor in, job_ready in IDLE), mem_* (source SRAM),
// npu_* (npu bus), res_* (result out), busy, err_timeout (sticky).
module npu_job_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned IN1_N       = 132,
  parameter int unsigned OUT1_M      = 10,
  parameter int unsigned NPU_RD_LAT  = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_src_base,
  input  logic        job_reuse_w,
  input  logic [3:0]  job_id,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        npu_ena,
  output logic        npu_wea,
  output logic [15:0] npu_addra,
  output logic [31:0] npu_dina,
  input  logic [31:0] npu_douta,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_id,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned IN_WORDS  = in_words(IN1_N);
  localparam int unsigned FC1_WORDS = fc1_words(OUT1_M, IN1_N);
  localparam int unsigned FC2_WORDS = fc2_words(OUT1_M);
  localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 1);

  localparam logic [11:0] IN_CNT  = 12'(IN_WORDS);
  localparam logic [11:0] FC1_CNT = 12'(FC1_WORDS);
  localparam logic [11:0] FC2_CNT = 12'(FC2_WORDS);
  localparam logic [15:0] OFF_FC1 = 16'(IN_WORDS);
  localparam logic [15:0] OFF_FC2 = 16'(IN_WORDS + FC1_WORDS);
  localparam logic [TW-1:0] POLL_LAST = TW'(TIMEOUT_CYC - 1);

  seq_state_e state, state_nx;

  logic [15:0]   base_q;
  logic          reuse_q;
  logic [3:0]    id_q;
  logic [TW-1:0] poll_cnt;
  logic          err_q;
  logic [31:0]   res_q;

  // vld_pipe[i]/tag_pipe[i]: read issued i cycles ago; tag 1 = result read
  logic [NPU_RD_LAT:1] vld_pipe, tag_pipe;
  logic req_vld, req_tag;
  logic done_seen, res_seen;

  logic        run, s_done;
  logic [15:0] s_base;
  logic [11:0] s_cnt;
  logic [2:0]  s_sel;
  npu_req_t    s_wr, ctrl_req, bus;

  logic unused_douta;
  assign unused_douta = ^npu_douta[31:24];

  npu_word_streamer u_stream (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .run      (run),
    .base     (s_base),
    .count    (s_cnt),
    .sel      (s_sel),
    .done     (s_done),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .wr       (s_wr)
  );

  assign done_seen = vld_pipe[NPU_RD_LAT] & ~tag_pipe[NPU_RD_LAT] & npu_douta[0];
  assign res_seen  = vld_pipe[NPU_RD_LAT] &  tag_pipe[NPU_RD_LAT];

  always_comb begin
    state_nx = state;
    run      = 1'b0;
    s_base   = base_q;
    s_cnt    = IN_CNT;
    s_sel    = SEL_IN;
    req_vld  = 1'b0;
    req_tag  = 1'b0;
    ctrl_req = '0;
    case (state)
      S_IDLE:     if (job_valid) state_nx = S_LOAD_IN;
      S_LOAD_IN: begin
        run = 1'b1;
        if (s_done) state_nx = reuse_q ? S_DRAIN : S_LOAD_FC1;
      end
      S_LOAD_FC1: begin
        run    = 1'b1;
        s_base = base_q + OFF_FC1;
        s_cnt  = FC1_CNT;
        s_sel  = SEL_FC1;
        if (s_done) state_nx = S_LOAD_FC2;
      end
      S_LOAD_FC2: begin
        run    = 1'b1;
        s_base = base_q + OFF_FC2;
        s_cnt  = FC2_CNT;
        s_sel  = SEL_FC2;
        if (s_done) state_nx = S_DRAIN;
      end
      S_DRAIN:    state_nx = S_START;
      S_START: begin
        ctrl_req.ena   = 1'b1;
        ctrl_req.wea   = 1'b1;
        ctrl_req.addra = npu_addr(SEL_CTRL, CTRL_IDX_START);
        state_nx       = S_POLL;
      end
      S_POLL: begin
        // done is a one-cycle pulse, so a status read goes out every cycle
        ctrl_req.ena   = 1'b1;
        ctrl_req.addra = npu_addr(SEL_CTRL, CTRL_IDX_DONE);
        req_vld        = 1'b1;
        if (done_seen)                  state_nx = S_RES_RD;
        else if (poll_cnt == POLL_LAST) state_nx = S_OUT;
      end
      S_RES_RD: begin
        ctrl_req.ena   = 1'b1;
        ctrl_req.addra = npu_addr(SEL_CTRL, CTRL_IDX_RESULT);
        req_vld        = 1'b1;
        req_tag        = 1'b1;
        state_nx       = S_RES_WAIT;
      end
      // status reads still in flight return here with tag 0 and are dropped
      S_RES_WAIT: if (res_seen) state_nx = S_OUT;
      S_OUT:      if (res_ready) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      base_q   <= '0;
      reuse_q  <= 1'b0;
      id_q     <= '0;
      poll_cnt <= '0;
      err_q    <= 1'b0;
      res_q    <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      state       <= state_nx;
      vld_pipe[1] <= req_vld;
      tag_pipe[1] <= req_tag;
      for (int i = 2; i <= int'(NPU_RD_LAT); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (state == S_IDLE && job_valid) begin
        base_q  <= job_src_base;
        reuse_q <= job_reuse_w;
        id_q    <= job_id;
        err_q   <= 1'b0;
      end
      if (state == S_START)     poll_cnt <= '0;
      else if (state == S_POLL) poll_cnt <= poll_cnt + 1'b1;
      if (state == S_POLL && state_nx == S_OUT) begin
        err_q <= 1'b1;
        res_q <= '0;
      end
      if (state == S_RES_WAIT && res_seen)
        res_q <= {{8{npu_douta[23]}}, npu_douta[23:0]};
    end
  end

  // streamer and control requests never overlap in time
  assign bus         = s_wr | ctrl_req;
  assign npu_ena     = bus.ena;
  assign npu_wea     = bus.wea;
  assign npu_addra   = bus.addra;
  assign npu_dina    = bus.dina;

  assign job_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign res_valid   = (state == S_OUT);
  assign res_data    = res_q;
  assign res_id      = id_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_npu_job_sequencer.sv
// Directed bench for npu_job_sequencer with a behavioural source SRAM and npu.
module tb_npu_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        job_valid, job_ready, job_reuse_w;
  logic [15:0] job_src_base;
  logic [3:0]  job_id;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        npu_ena, npu_wea;
  logic [15:0] npu_addra;
  logic [31:0] npu_dina, npu_douta;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_id;
  logic        busy, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npu_job_sequencer #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .job_valid(job_valid), .job_ready(job_ready), .job_src_base(job_src_base),
    .job_reuse_w(job_reuse_w), .job_id(job_id),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .npu_ena(npu_ena), .npu_wea(npu_wea), .npu_addra(npu_addra),
    .npu_dina(npu_dina), .npu_douta(npu_douta),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .err_timeout(err_timeout)
  );

  // ---------------- source SRAM ----------------
  logic [31:0] sram [0:2047];
  always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr[10:0]];

  // ---------------- npu model ----------------
  typedef struct { int cyc; logic [15:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];
  logic [31:0] in_m [0:32];
  logic [31:0] fc1_m [0:329];
  logic [31:0] fc2_m [0:2];
  logic [31:0] rd1;
  logic [23:0] res24;
  logic        no_done = 1'b0;
  int done_cnt = 0, cyc = 0, poll_reads = 0, res_reads = 0, accepts = 0;

  function automatic logic [23:0] npu_compute();
    int acc, out, e;
    byte a, b;
    out = 0;
    for (int j = 0; j < 10; j++) begin
      acc = 0;
      for (int i = 0; i < 132; i++) begin
        e = j * 132 + i;
        a = in_m[i/4][8*(i%4) +: 8];
        b = fc1_m[e/4][8*(e%4) +: 8];
        acc += int'(a) * int'(b);
      end
      if (acc < 0) acc = 0;
      b = fc2_m[j/4][8*(j%4) +: 8];
      out += acc * int'(b);
    end
    return 24'(out);
  endfunction

  always @(posedge clk) begin
    wr_t w;
    cyc <= cyc + 1;
    if (rst_ni && job_valid && job_ready) accepts <= accepts + 1;
    if (done_cnt > 0) done_cnt <= done_cnt - 1;
    if (npu_ena && npu_wea) begin
      w.cyc = cyc; w.a = npu_addra; w.d = npu_dina;
      wlog.push_back(w);
      case (npu_addra[14:12])
        3'b000: if (npu_addra[11:0] < 12'd33)  in_m[npu_addra[11:0]]  <= npu_dina;
        3'b011: if (npu_addra[11:0] < 12'd330) fc1_m[npu_addra[11:0]] <= npu_dina;
        3'b100: if (npu_addra[11:0] < 12'd3)   fc2_m[npu_addra[11:0]] <= npu_dina;
        3'b101: if (npu_addra[11:0] == 12'd1) begin
          res24    <= npu_compute();
          done_cnt <= no_done ? 0 : 6;
        end
        default: ;
      endcase
    end
    // idle returns are all ones so a mistimed sample looks like done
    if (npu_ena && !npu_wea) begin
      if (npu_addra == 16'h5000) begin
        rd1 <= {31'b0, done_cnt == 1};
        poll_reads <= poll_reads + 1;
      end else if (npu_addra == 16'h5001) begin
        rd1 <= {8'h00, res24};
        res_reads <= res_reads + 1;
      end else rd1 <= 32'hDEAD_BEEF;
    end else rd1 <= 32'hFFFF_FFFF;
    npu_douta <= rd1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int b, input logic [7:0] iv, input logic [7:0] w1, input logic [7:0] w2);
    for (int i = 0; i < 33; i++)  sram[b+i]     = {4{iv}};
    for (int i = 0; i < 330; i++) sram[b+33+i]  = {4{w1}};
    for (int i = 0; i < 3; i++)   sram[b+363+i] = {4{w2}};
  endtask

  task automatic start_job(input logic [15:0] b, input logic r, input logic [3:0] id);
    @(posedge clk); #1;
    job_valid = 1'b1; job_src_base = b; job_reuse_w = r; job_id = id;
    @(negedge clk); chk("job_ready_idle", job_ready, 1);
    @(posedge clk); #1 job_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < budget) begin @(negedge clk); n++; end
    chk(tag, res_valid, 1);
  endtask

  task automatic handshake();
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("hs_valid_drop", res_valid, 0);
    chk("hs_job_ready", job_ready, 1);
  endtask

  // Expected npu write stream: every source word in order, consecutive cycles, then start.
  task automatic check_writes(input string tag, input int b, input int start, input logic reuse);
    int n, bad, sel, k;
    logic [15:0] ea;
    n = reuse ? 33 : 366;
    bad = 0;
    chk({tag, "_count"}, wlog.size() - start, n + 1);
    for (int i = 0; i <= n; i++) begin
      if (i == n) begin
        ea = 16'h5001;
      end else begin
        sel = (i < 33) ? 0 : (i < 363) ? 3 : 4;
        k   = (i < 33) ? i : (i < 363) ? i - 33 : i - 363;
        ea  = {1'b0, 3'(sel), 12'(k)};
      end
      if (start + i >= wlog.size()) bad++;
      else if (wlog[start+i].a !== ea ||
               wlog[start+i].d !== ((i == n) ? 32'h0 : sram[b+i]) ||
               wlog[start+i].cyc != wlog[start].cyc + i) bad++;
    end
    chk({tag, "_order"}, bad, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ws, t0, pr, rr, ac;
    logic stable;
    rst_ni = 1'b0; job_valid = 1'b0; job_src_base = '0; job_reuse_w = 1'b0;
    job_id = '0; res_ready = 1'b0;
    for (int i = 0; i < 2048; i++) sram[i] = 32'h0;
    fill(16'h0100, 8'h01, 8'h01, 8'h01);
    fill(16'h0300, 8'h02, 8'h55, 8'h55);
    fill(16'h0500, 8'h01, 8'h01, 8'hFF);

    #12;
    chk("rst_flags", {job_ready, busy, mem_en, npu_ena, npu_wea, res_valid, err_timeout}, 7'b1000000);
    chk("rst_res_data", res_data, 0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // 1: full job
    ws = wlog.size();
    start_job(16'h0100, 1'b0, 4'h3);
    t0 = cyc;
    @(negedge clk);
    chk("t1_first_read", {busy, job_ready, mem_en, mem_addr}, {3'b101, 16'h0100});
    wait_res("t1_res_valid", 1000);
    chk("t1_latency", cyc - t0, 379);
    chk("t1_res_data", res_data, 32'h0000_0528);
    chk("t1_res_id", res_id, 4'h3);
    check_writes("t1_wr", 16'h0100, ws, 1'b0);
    handshake();

    // 2: weights resident, only in_vec reloaded
    ws = wlog.size();
    start_job(16'h0300, 1'b1, 4'h5);
    t0 = cyc;
    wait_res("t2_res_valid", 500);
    chk("t2_latency", cyc - t0, 46);
    chk("t2_res_data", res_data, 32'h0000_0A50);
    check_writes("t2_wr", 16'h0300, ws, 1'b1);
    handshake();

    // 3: negative fc2, res_ready already high -> single-cycle transfer
    @(posedge clk); #1 res_ready = 1'b1;
    start_job(16'h0500, 1'b0, 4'h6);
    wait_res("t3_res_valid", 1000);
    chk("t3_res_data", res_data, 32'hFFFF_FAD8);
    @(negedge clk);
    chk("t3_same_cycle_xfer", {res_valid, job_ready}, 2'b01);
    @(posedge clk); #1 res_ready = 1'b0;

    // 4: done never arrives -> timeout after 64 polls
    no_done = 1'b1;
    pr = poll_reads; rr = res_reads;
    start_job(16'h0300, 1'b1, 4'h8);
    wait_res("t4_res_valid", 500);
    chk("t4_err", err_timeout, 1);
    chk("t4_res_data", res_data, 0);
    chk("t4_poll_reads", poll_reads - pr, 64);
    chk("t4_no_res_read", res_reads - rr, 0);
    handshake();
    chk("t4_err_sticky", err_timeout, 1);
    no_done = 1'b0;
    start_job(16'h0100, 1'b0, 4'h9);
    @(negedge clk);
    chk("t4_err_cleared", err_timeout, 0);
    wait_res("t4b_res_valid", 1000);
    chk("t4b_res_data", res_data, 32'h0000_0528);
    handshake();

    // 5: backpressure with job_valid held during the whole job
    ac = accepts;
    start_job(16'h0300, 1'b1, 4'h7);
    job_valid = 1'b1; job_id = 4'hE; job_src_base = 16'h0100;
    wait_res("t5_res_valid", 500);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_data === 32'h0000_0A50 &&
            res_id === 4'h7 && job_ready === 1'b0)) stable = 1'b0;
    end
    chk("t5_stable", stable, 1);
    @(posedge clk); #1 res_ready = 1'b1; job_valid = 1'b0;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("t5_idle_after", {res_valid, busy}, 2'b00);
    chk("t5_accepts", accepts - ac, 1);

    // 6: reset in the middle of the fc1 load
    start_job(16'h0100, 1'b0, 4'hA);
    repeat (45) @(posedge clk);
    #2;
    chk("t6_in_fc1", mem_addr, 16'h012D);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_flags", {job_ready, busy, mem_en, npu_ena, npu_wea, res_valid, err_timeout}, 7'b1000000);
    chk("t6_rst_addr", {mem_addr, npu_addra}, 32'h0);
    chk("t6_rst_data", npu_dina | res_data | {28'h0, res_id}, 32'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    ws = wlog.size();
    start_job(16'h0100, 1'b0, 4'hB);
    wait_res("t6_res_valid", 1000);
    chk("t6_res_data", res_data, 32'h0000_0528);
    chk("t6_res_id", res_id, 4'hB);
    check_writes("t6_wr", 16'h0100, ws, 1'b0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
